// File: rtl/result_forward_pipe_pkg.sv
// Shared types and default widths for the post-execute result/forwarding pipe.
package fwd_pipe_pkg;

  localparam int unsigned DEF_LANES        = 2;
  localparam int unsigned DEF_DEPTH        = 7;
  localparam int unsigned DEF_DATA_W       = 128;
  localparam int unsigned DEF_REG_AW       = 7;
  localparam int unsigned DEF_SRC_PER_LANE = 3;
  localparam int unsigned DEF_LAT_W        = 3;
  localparam int unsigned UNIT_W           = 3;

  // Load/store entries carry the address; the top level swaps in memory data at writeback.
  localparam logic [UNIT_W-1:0] UNIT_LS = 3'd7;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [DEF_REG_AW-1:0] rt;
    logic [UNIT_W-1:0]     unit;
    logic [DEF_LAT_W-1:0]  lat;
    logic [DEF_DATA_W-1:0] data;
  } pipe_entry_t;

  // A latency of zero is treated as one: nothing is forwardable before stage 1.
  function automatic logic [DEF_LAT_W-1:0] eff_lat(input logic [DEF_LAT_W-1:0] lat);
    return (lat == '0) ? DEF_LAT_W'(1) : lat;
  endfunction

endpackage

// File: rtl/result_forward_pipe_if.sv
// Issue, decode-source, forwarding and writeback bundle of result_forward_pipe.
interface result_forward_pipe_if
  import fwd_pipe_pkg::*;
#(
  parameter int unsigned LANES        = DEF_LANES,
  parameter int unsigned SRC_PER_LANE = DEF_SRC_PER_LANE,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned REG_AW       = DEF_REG_AW,
  parameter int unsigned LAT_W        = DEF_LAT_W
) ();

  logic [LANES-1:0]                     issue_valid;
  logic [LANES-1:0]                     issue_we;
  logic [LANES*REG_AW-1:0]              issue_rt;
  logic [LANES*UNIT_W-1:0]              issue_unit;
  logic [LANES*LAT_W-1:0]               issue_lat;
  logic [LANES*DATA_W-1:0]              issue_result;
  logic                                 flush;
  logic [LANES*SRC_PER_LANE-1:0]        src_valid;
  logic [LANES*SRC_PER_LANE*REG_AW-1:0] src_reg;
  logic [LANES*SRC_PER_LANE*DATA_W-1:0] fwd_data;
  logic [LANES*SRC_PER_LANE-1:0]        fwd_sel;
  logic                                 hazard_stall;
  logic [LANES-1:0]                     wb_valid;
  logic [LANES*REG_AW-1:0]              wb_rt;
  logic [LANES*UNIT_W-1:0]              wb_unit;
  logic [LANES*DATA_W-1:0]              wb_data;

  modport master (
    output issue_valid, issue_we, issue_rt, issue_unit, issue_lat, issue_result,
    output flush, src_valid, src_reg,
    input  fwd_data, fwd_sel, hazard_stall,
    input  wb_valid, wb_rt, wb_unit, wb_data
  );

  modport slave (
    input  issue_valid, issue_we, issue_rt, issue_unit, issue_lat, issue_result,
    input  flush, src_valid, src_reg,
    output fwd_data, fwd_sel, hazard_stall,
    output wb_valid, wb_rt, wb_unit, wb_data
  );

endinterface

// File: rtl/result_forward_pipe_lookup.sv
// fwd_lookup: combinational youngest-producer matcher for one source operand.
module fwd_lookup
  import fwd_pipe_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  pipe_entry_t           i_pipe [1:DEPTH][LANES],
  input  logic                  i_src_valid,
  input  logic [DEF_REG_AW-1:0] i_src_reg,
  output logic [DEF_DATA_W-1:0] o_data,
  output logic                  o_sel,
  output logic                  o_stall
);

  logic                  w_hit;
  int unsigned           w_age;
  logic [DEF_LAT_W-1:0]  w_lat;
  logic [DEF_DATA_W-1:0] w_data;
  logic                  w_ready;
  logic                  w_unused_units;

  // Oldest-to-youngest, low-to-high lane: the last hit is the youngest, highest-lane producer.
  always_comb begin
    w_hit          = 1'b0;
    w_age          = 0;
    w_lat          = '0;
    w_data         = '0;
    w_unused_units = 1'b0;
    for (int unsigned s = DEPTH; s >= 1; s--) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        w_unused_units = w_unused_units ^ (^i_pipe[s][l].unit);
        if (i_src_valid && i_pipe[s][l].valid && i_pipe[s][l].we &&
            (i_pipe[s][l].rt == i_src_reg)) begin
          w_hit  = 1'b1;
          w_age  = s;
          w_lat  = i_pipe[s][l].lat;
          w_data = i_pipe[s][l].data;
        end
      end
    end
    w_ready = (w_age >= 32'(eff_lat(w_lat)));
    o_sel   = w_hit & w_ready;
    o_stall = w_hit & ~w_ready;
    o_data  = o_sel ? w_data : '0;
  end

endmodule

// File: rtl/result_forward_pipe.sv
// DEPTH-stage result shift pipe with latency-aware forwarding and writeback.
// Optional FWD_PERF_CNT_EN adds saturating stall/forward performance counters.
module result_forward_pipe
  import fwd_pipe_pkg::*;
#(
  parameter int unsigned LANES        = DEF_LANES,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned REG_AW       = DEF_REG_AW,
  parameter int unsigned SRC_PER_LANE = DEF_SRC_PER_LANE,
  parameter int unsigned LAT_W        = DEF_LAT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  result_forward_pipe_if.slave bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_fwd_cnt
`endif
);

  localparam int unsigned NSRC = LANES * SRC_PER_LANE;

  pipe_entry_t       r_pipe      [1:DEPTH][LANES];
  pipe_entry_t       w_stage1_in [LANES];
  pipe_entry_t       w_stage2_in [LANES];
  logic [DATA_W-1:0] w_fwd_data  [NSRC];
  logic [NSRC-1:0]   w_fwd_sel;
  logic [NSRC-1:0]   w_stall;
  logic              w_hazard;

  // Flush kills both the incoming issue and whatever is leaving stage 1 this edge.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_stage1_in[l].valid = bus.issue_valid[l] & ~bus.flush;
      w_stage1_in[l].we    = bus.issue_we[l];
      w_stage1_in[l].rt    = bus.issue_rt[l*REG_AW +: REG_AW];
      w_stage1_in[l].unit  = bus.issue_unit[l*UNIT_W +: UNIT_W];
      w_stage1_in[l].lat   = bus.issue_lat[l*LAT_W +: LAT_W];
      w_stage1_in[l].data  = bus.issue_result[l*DATA_W +: DATA_W];
      w_stage2_in[l]       = r_pipe[1][l];
      w_stage2_in[l].valid = r_pipe[1][l].valid & ~bus.flush;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 1; s <= DEPTH; s++) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          r_pipe[s][l] <= '0;
        end
      end
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        r_pipe[1][l] <= w_stage1_in[l];
        r_pipe[2][l] <= w_stage2_in[l];
        for (int unsigned s = 3; s <= DEPTH; s++) begin
          r_pipe[s][l] <= r_pipe[s-1][l];
        end
      end
    end
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_lookup #(
      .LANES (LANES),
      .DEPTH (DEPTH)
    ) u_lookup (
      .i_pipe      (r_pipe),
      .i_src_valid (bus.src_valid[k]),
      .i_src_reg   (bus.src_reg[k*REG_AW +: REG_AW]),
      .o_data      (w_fwd_data[k]),
      .o_sel       (w_fwd_sel[k]),
      .o_stall     (w_stall[k])
    );
    assign bus.fwd_data[k*DATA_W +: DATA_W] = w_fwd_data[k];
  end

  assign w_hazard         = |w_stall;
  assign bus.fwd_sel      = w_fwd_sel;
  assign bus.hazard_stall = w_hazard;

  for (genvar l = 0; l < LANES; l++) begin : g_wb
    assign bus.wb_valid[l]                   = r_pipe[DEPTH][l].valid & r_pipe[DEPTH][l].we;
    assign bus.wb_rt[l*REG_AW +: REG_AW]     = r_pipe[DEPTH][l].rt;
    assign bus.wb_unit[l*UNIT_W +: UNIT_W]   = r_pipe[DEPTH][l].unit;
    assign bus.wb_data[l*DATA_W +: DATA_W]   = r_pipe[DEPTH][l].data;
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_fwd_cnt;
  logic [32:0] w_fwd_sum;

  assign w_fwd_sum = {1'b0, r_perf_fwd_cnt} + 33'($countones(w_fwd_sel));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_fwd_cnt   <= '0;
    end else begin
      if (w_hazard && (r_perf_stall_cnt != '1)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      r_perf_fwd_cnt <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_fwd_cnt   = r_perf_fwd_cnt;
`endif

endmodule

// File: doc/result_forward_pipe.md
Name: result_forward_pipe

Overview:
- Parametrised post-execute result pipeline for the dual-issue SPU core; replaces the fixed chain of per-stage pipeline registers and the separate forwarding-control block.
- Carries each lane's result, destination register, unit ID and latency from EX through DEPTH stages to writeback.
- Performs latency-aware operand forwarding for every source operand of every lane.
- Raises a hazard stall when the youngest matching producer's result is not yet ready.

Parameters:
- LANES, 2, issue lanes (lane 0 even, lane 1 odd; a higher lane index is later in program order)
- DEPTH, 7, pipeline stages after EX; a stage-s entry has age s
- DATA_W, 128, result width
- REG_AW, 7, register address width
- SRC_PER_LANE, 3, source operands per lane (RA, RB, RC)
- LAT_W, 3, latency field width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- issue_valid  in  LANES  an EX result is present this cycle
- issue_we  in  LANES  register write enable
- issue_rt  in  LANES*REG_AW  destination register
- issue_unit  in  LANES*3  unit ID
- issue_lat  in  LANES*LAT_W  age at which the result becomes forwardable
- issue_result  in  LANES*DATA_W  EX result
- flush  in  1  kill younger work
- src_valid  in  LANES*SRC_PER_LANE  source operand is used
- src_reg  in  LANES*SRC_PER_LANE*REG_AW  source register addresses in decode
- fwd_data  out  LANES*SRC_PER_LANE*DATA_W  forwarded operand value
- fwd_sel  out  LANES*SRC_PER_LANE  1 = use fwd_data, 0 = use register-file value
- hazard_stall  out  1  upstream must insert a nop and hold the PC
- wb_valid  out  LANES  writeback strobe (valid && we at stage DEPTH)
- wb_rt  out  LANES*REG_AW  writeback register
- wb_unit  out  LANES*3  writeback unit ID
- wb_data  out  LANES*DATA_W  writeback data

Behaviour:
- State is DEPTH x LANES entries {valid, we, rt, unit, lat, data}. There is no FSM; this is a shift pipe.
- Every cycle, stage s+1 takes stage s, and stage 1 takes the issue inputs.
- The pipe never stalls. A bubble is issue_valid=0.
- Reset clears every valid bit and every data field immediately, including mid-operation. All outputs are 0 while reset is asserted and on the first cycle after it.
- flush: the current issue is captured as invalid, and stage-1 entries are invalidated on the same edge. Stages 2..DEPTH are unaffected.
- Lookup is combinational over stages 1..DEPTH:
  - A candidate requires valid && we && rt == src_reg.
  - The youngest candidate wins (lowest age). At equal age the higher lane index wins.
  - The winner is ready if age >= lat. lat = 0 is treated as 1.
  - Ready winner: fwd_sel = 1, fwd_data = winner data.
  - Not-ready winner: fwd_sel = 0 and hazard_stall = 1.
  - Ready-ness is evaluated only on the youngest candidate. An older ready producer must not mask a younger unready one.
- A source with src_valid = 0 never matches or stalls.
- No candidate: fwd_sel = 0, fwd_data = 0. The register file supplies the value, since it writes in the first half of the cycle.
- lat > DEPTH: the entry never forwards. Consumers stall until it retires, then read the register file.
- Writeback is driven by the stage-DEPTH registers, so wb_* has zero added latency from stage DEPTH.
- Total latency from issue to wb_valid is DEPTH cycles.
- Intra-cycle issue: a same-cycle issue is not visible to lookup until it reaches stage 1, one cycle later.
- Unit ID 7 (load/store) entries still forward; their data is the address, and the top level substitutes memory data before writeback.

Optional Feature:
- Macro: FWD_PERF_CNT_EN
- Defined:
  - Adds outputs perf_stall_cnt (32 bits) and perf_fwd_cnt (32 bits).
  - perf_stall_cnt increments on each hazard_stall cycle.
  - perf_fwd_cnt increments by the number of fwd_sel bits set each cycle.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fwd_pipe_pkg holds:
  - the pipe_entry_t struct
  - unit ID constants (UNIT_LS = 3'd7)
  - default widths
- Sub-module fwd_lookup: a combinational matcher for one source against the full entry array, outputting data, sel and stall. It is instantiated LANES*SRC_PER_LANE times.

Test Plan (DEPTH=7, LANES=2):
- Lane 0 issues rt=3, lat=2, data=0xA5 (all 128 bits); next cycle, lane 1 src RA=3 -> hazard_stall=1, fwd_sel=0. One cycle later -> fwd_sel=1, fwd_data=0xA5, stall=0.
- Same-age conflict: lane 0 and lane 1 both write rt=5, data 0x11 and 0x22, lat=1; a later src=5 -> fwd_data=0x22.
- Youngest rule: rt=9 at age 4 (lat 1, data 0x1) and rt=9 at age 1 (lat 3) -> stall=1. No forward of 0x1 may occur.
- Flush with stage 1 holding rt=4 (lat 1) and a new rt=6 issuing -> after the edge, neither matches. wb_valid never fires for either.
- Retirement: rt=2, data 0x7, issued at cycle 0 -> wb_valid[0]=1, wb_rt=2, wb_data=0x7 at cycle 7, then no match at cycle 8.
- Reset asserted asynchronously mid-stream with 5 live entries -> all outputs 0 immediately. After release, src=any gives fwd_sel=0 and stall=0.
